// File: rtl/dual_fetch_unit_pkg.sv
// kl_fetch_pkg: shared constants and types for the dual-issue fetch front end.
//   PC_W / INSN_W : default address and instruction widths
//   pc_t / insn_t : address and instruction word types
//   TAKE_*        : encoding of the issue stage's per-cycle consume count
package kl_fetch_pkg;

   localparam int PC_W   = 9;
   localparam int INSN_W = 16;

   typedef logic [PC_W-1:0]   pc_t;
   typedef logic [INSN_W-1:0] insn_t;

   localparam logic [1:0] TAKE_NONE = 2'd0;
   localparam logic [1:0] TAKE_ONE  = 2'd1;
   localparam logic [1:0] TAKE_TWO  = 2'd2;

endpackage

// File: rtl/dual_fetch_unit_queue.sv
// fetch_queue: circular instruction buffer for the fetch front end.
//   clk, reset      : clock, synchronous active-high reset
//   flush_i         : drop all entries (branch redirect)
//   wr_en_i/wr_data_i : push one word at tail
//   pop_i           : words removed at head this cycle (already clamped to count_o)
//   rd0_o / rd1_o   : raw entries at head and head+1 (caller masks with count)
//   count_o         : number of valid entries
module fetch_queue
   import kl_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = INSN_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          wr_en_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic [1:0]    pop_i,
   output logic [W-1:0]  rd0_o,
   output logic [W-1:0]  rd1_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;

   // Storage has no reset; entries are only observed through count.
   always_ff @(posedge clk) begin
      if (wr_en_i && !reset && !flush_i) mem_q[tail_q] <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         tail_q  <= tail_q + AW'(wr_en_i);
         head_q  <= head_q + AW'(pop_i);
         count_q <= count_q + CW'(wr_en_i) - CW'(pop_i);
      end
   end

   assign rd0_o   = mem_q[head_q];
   assign rd1_o   = mem_q[head_q + AW'(1)];
   assign count_o = count_q;

endmodule

// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit: instruction fetch front end feeding the p0/p1 issue pair.
//   clk, reset                 : clock, synchronous active-high reset
//   imem_addr/imem_rd          : read request to the 1-cycle-latency instruction memory
//   imem_rdata                 : data for the previous cycle's request
//   p0_IR_out/p1_IR_out        : two oldest queued words (0 when not valid)
//   p0_valid/p1_valid          : queue holds >=1 / >=2 words
//   take                       : words consumed this cycle (0..2; 3 treated as 2)
//   redirect/redirect_pc       : flush the queue and refetch from redirect_pc
// ASSERT_TAKE enables the simulation check that take never exceeds the valid count.
module dual_fetch_unit #(
   parameter int              PC_W        = kl_fetch_pkg::PC_W,
   parameter int              INSN_W      = kl_fetch_pkg::INSN_W,
   parameter int              DEPTH       = 4,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter bit              ASSERT_TAKE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   imem_addr,
   output logic              imem_rd,
   input  logic [INSN_W-1:0] imem_rdata,
   output logic [INSN_W-1:0] p0_IR_out,
   output logic [INSN_W-1:0] p1_IR_out,
   output logic              p0_valid,
   output logic              p1_valid,
   input  logic [1:0]        take,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc
);
   import kl_fetch_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [PC_W-1:0]   pc_q, pc_d;
   logic              inflight_q, inflight_d;
   logic [CW-1:0]     count;
   logic [INSN_W-1:0] rd0, rd1;
   logic [1:0]        take_eff, pop;
   logic              credit, wr_en;

   always_comb begin
      take_eff   = (take > TAKE_TWO) ? TAKE_TWO : take;
      // Over-take is clamped; count is at most 1 whenever it is the smaller side.
      pop        = (CW'(take_eff) > count) ? count[1:0] : take_eff;
      // Same-cycle pop is deliberately not credited, so the queue cannot overflow.
      credit     = (int'(count) + int'(inflight_q)) < DEPTH;
      // A word returning during a redirect belongs to the abandoned stream.
      wr_en      = inflight_q && !redirect && !reset;
      imem_rd    = 1'b0;
      imem_addr  = pc_q;
      pc_d       = pc_q;
      inflight_d = 1'b0;
      if (reset) begin
         imem_rd = 1'b0;
      end else if (redirect) begin
         imem_rd    = 1'b1;
         imem_addr  = redirect_pc;
         pc_d       = redirect_pc + PC_W'(1);
         inflight_d = 1'b1;
      end else if (credit) begin
         imem_rd    = 1'b1;
         pc_d       = pc_q + PC_W'(1);
         inflight_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_queue #(.DEPTH(DEPTH), .W(INSN_W)) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (redirect),
      .wr_en_i   (wr_en),
      .wr_data_i (imem_rdata),
      .pop_i     (pop),
      .rd0_o     (rd0),
      .rd1_o     (rd1),
      .count_o   (count)
   );

   // Outputs are forced idle during the reset cycle itself, before state clears.
   assign p0_valid  = !reset && (count >= CW'(1));
   assign p1_valid  = !reset && (count >= CW'(2));
   assign p0_IR_out = p0_valid ? rd0 : '0;
   assign p1_IR_out = p1_valid ? rd1 : '0;

   always_ff @(posedge clk) begin
      if (ASSERT_TAKE && !reset && !redirect)
         assert (take != 2'd3 && CW'(take) <= count);
   end

endmodule

// File: tb/tb_dual_fetch_unit.sv
module tb_dual_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  imem_addr;
   logic        imem_rd;
   logic [15:0] imem_rdata = '0;
   logic [15:0] p0_IR_out, p1_IR_out;
   logic        p0_valid, p1_valid;
   logic [1:0]  take = 2'd0;
   logic        redirect = 1'b0;
   logic [8:0]  redirect_pc = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dual_fetch_unit #(.PC_W(9), .INSN_W(16), .DEPTH(4), .RESET_PC(9'd0), .ASSERT_TAKE(1'b0)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .imem_rdata(imem_rdata), .p0_IR_out(p0_IR_out), .p1_IR_out(p1_IR_out),
      .p0_valid(p0_valid), .p1_valid(p1_valid), .take(take),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   // Memory: mem[i] = A000+i, one-cycle read; garbage when not read.
   always @(posedge clk)
      imem_rdata <= imem_rd ? (16'hA000 + 16'(imem_addr)) : 16'($urandom);

   // Reference model: a word queue plus the fetch pointer and one pending request.
   logic [15:0] mq[$];
   logic [8:0]  m_pc = '0;
   bit          m_inf = 1'b0;
   logic [8:0]  m_iaddr = '0;

   function automatic bit m_rd();
      return !reset && (redirect || (mq.size() + int'(m_inf) < 4));
   endfunction

   function automatic logic [8:0] m_addr();
      return redirect ? redirect_pc : m_pc;
   endfunction

   task automatic drive(input bit rst, input bit rdr, input logic [8:0] rpc, input logic [1:0] tk);
      @(negedge clk);
      reset = rst; redirect = rdr; redirect_pc = rpc; take = tk;
      #1;
   endtask

   task automatic adv();
      bit rd;
      logic [8:0] a;
      int t, n;
      rd = m_rd();
      a  = m_addr();
      @(posedge clk);
      if (reset) begin
         mq.delete(); m_pc = '0; m_inf = 1'b0;
      end else if (redirect) begin
         mq.delete(); m_inf = 1'b1; m_iaddr = redirect_pc; m_pc = redirect_pc + 9'd1;
      end else begin
         t = (take == 2'd3) ? 2 : int'(take);
         n = (t < mq.size()) ? t : mq.size();
         repeat (n) void'(mq.pop_front());
         if (m_inf) mq.push_back(16'hA000 + 16'(m_iaddr));
         m_inf = rd;
         if (rd) begin m_iaddr = a; m_pc = m_pc + 9'd1; end
      end
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         drive(1, 0, 0, 0);
         n_tests++;
         if ({imem_rd, p0_valid, p1_valid, p0_IR_out, p1_IR_out} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%b v0=%b v1=%b p0=%h p1=%h want all 0",
                     imem_rd, p0_valid, p1_valid, p0_IR_out, p1_IR_out);
         end
         adv();
      end
   endtask

   task automatic test_fill();
      for (int c = 0; c < 8; c++) begin
         drive(0, 0, 0, 0);
         n_tests++;
         if (imem_rd !== 1'(c < 4) || (c < 4 && imem_addr !== 9'(c))) begin
            n_fail++;
            $display("FAIL fill_req c%0d: got rd=%b addr=%h want rd=%b addr=%h", c, imem_rd, imem_addr, c < 4, c);
         end
         n_tests++;
         if (p0_valid !== 1'(c >= 2) || p1_valid !== 1'(c >= 3)) begin
            n_fail++;
            $display("FAIL fill_valid c%0d: got v0=%b v1=%b want v0=%b v1=%b", c, p0_valid, p1_valid, c >= 2, c >= 3);
         end
         if (c >= 3) begin
            n_tests++;
            if (p0_IR_out !== 16'hA000 || p1_IR_out !== 16'hA001) begin
               n_fail++;
               $display("FAIL fill_data c%0d: got p0=%h p1=%h want A000 A001", c, p0_IR_out, p1_IR_out);
            end
         end
         adv();
      end
   endtask

   logic [15:0] nxt;

   task automatic test_dual();
      int low = 0;
      nxt = 16'hA000;
      for (int c = 0; c < 24; c++) begin
         drive(0, 0, 0, 0);
         if (p1_valid) begin
            n_tests++;
            if (p0_IR_out !== nxt || p1_IR_out !== nxt + 16'd1) begin
               n_fail++;
               $display("FAIL dual_seq: got p0=%h p1=%h want %h %h", p0_IR_out, p1_IR_out, nxt, nxt + 16'd1);
            end
            take = 2'd2; nxt = nxt + 16'd2;
         end else begin
            low++;
            if (c > 2) begin
               n_tests++;
               if (p0_valid && p0_IR_out !== nxt) begin
                  n_fail++;
                  $display("FAIL dual_single_left: got p0=%h want %h", p0_IR_out, nxt);
               end
            end
         end
         adv();
      end
      n_tests++;
      if (low < 3) begin
         n_fail++;
         $display("FAIL dual_p1_toggle: got %0d p1-low cycles want >=3", low);
      end
   endtask

   task automatic test_single();
      for (int c = 0; c < 20; c++) begin
         drive(0, 0, 0, 0);
         if (c >= 4) begin
            n_tests++;
            if (p0_valid !== 1'b1 || imem_rd !== m_rd()) begin
               n_fail++;
               $display("FAIL single_flow c%0d: got v0=%b rd=%b want v0=1 rd=%b", c, p0_valid, imem_rd, m_rd());
            end
         end
         if (p0_valid) begin
            n_tests++;
            if (p0_IR_out !== nxt) begin
               n_fail++;
               $display("FAIL single_seq: got p0=%h want %h", p0_IR_out, nxt);
            end
            take = 2'd1; nxt = nxt + 16'd1;
         end
         adv();
      end
   endtask

   task automatic test_overtake();
      logic [15:0] e;
      drive(1, 0, 0, 0); adv();
      drive(0, 0, 0, 0); adv();
      drive(0, 0, 0, 0); adv();
      drive(0, 0, 0, 2);  // one word queued, two requested
      n_tests++;
      if (p0_valid !== 1'b1 || p1_valid !== 1'b0 || p0_IR_out !== 16'hA000) begin
         n_fail++;
         $display("FAIL overtake_pre: got v0=%b v1=%b p0=%h want 1 0 A000", p0_valid, p1_valid, p0_IR_out);
      end
      adv();
      drive(0, 0, 0, 0);
      n_tests++;
      if (p0_IR_out !== 16'hA001 || p1_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overtake_clamp: got p0=%h v1=%b want A001 0", p0_IR_out, p1_valid);
      end
      adv();
      repeat (8) begin drive(0, 0, 0, 0); adv(); end
      drive(0, 0, 0, 3);
      n_tests++;
      if (imem_rd !== 1'b0 || p1_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL take3_full: got rd=%b v1=%b want 0 1", imem_rd, p1_valid);
      end
      e = mq[2];
      adv();
      drive(0, 0, 0, 0);
      n_tests++;
      if (p0_IR_out !== e || p1_valid !== 1'b1 || imem_rd !== 1'b1) begin
         n_fail++;
         $display("FAIL take3_pop2: got p0=%h v1=%b rd=%b want %h 1 1", p0_IR_out, p1_valid, imem_rd, e);
      end
      adv();
   endtask

   task automatic test_redirect();
      int j = 0;
      drive(1, 0, 0, 0); adv();
      for (int c = 0; c < 6; c++) begin
         drive(0, 0, 0, 0);
         if (p0_valid) take = 2'd1;
         adv();
      end
      drive(0, 1, 9'h1F0, 1);
      n_tests++;
      if (imem_rd !== 1'b1 || imem_addr !== 9'h1F0) begin
         n_fail++;
         $display("FAIL redirect_req: got rd=%b addr=%h want 1 1F0", imem_rd, imem_addr);
      end
      adv();
      drive(0, 0, 0, 0);
      n_tests++;
      if (p0_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_flush: got v0=%b want 0", p0_valid);
      end
      adv();
      for (int k = 0; k < 24; k++) begin
         drive(0, 0, 0, 0);
         if (k == 0) begin
            n_tests++;
            if (p0_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL redirect_latency: got v0=%b want 1", p0_valid);
            end
         end
         if (p0_valid) begin
            n_tests++;
            if (p0_IR_out !== 16'hA000 + 16'((9'h1F0 + 9'(j)) & 9'h1FF)) begin
               n_fail++;
               $display("FAIL redirect_seq j%0d: got p0=%h want %h", j, p0_IR_out,
                        16'hA000 + 16'((9'h1F0 + 9'(j)) & 9'h1FF));
            end
            take = 2'd1; j++;
         end
         adv();
      end
      n_tests++;
      if (j < 17) begin
         n_fail++;
         $display("FAIL redirect_wrap: got %0d words want >=17", j);
      end
      drive(0, 1, 9'h050, 0); adv();
      drive(0, 1, 9'h080, 0);
      n_tests++;
      if (imem_rd !== 1'b1 || imem_addr !== 9'h080) begin
         n_fail++;
         $display("FAIL b2b_req: got rd=%b addr=%h want 1 080", imem_rd, imem_addr);
      end
      adv();
      drive(0, 0, 0, 0); adv();
      drive(0, 0, 0, 0);
      n_tests++;
      if (p0_valid !== 1'b1 || p0_IR_out !== 16'hA080) begin
         n_fail++;
         $display("FAIL b2b_data: got v0=%b p0=%h want 1 A080", p0_valid, p0_IR_out);
      end
      adv();
   endtask

   task automatic test_midreset();
      drive(1, 0, 0, 0); adv();
      repeat (4) begin drive(0, 0, 0, 0); adv(); end
      drive(1, 0, 0, 0);  // count=3 with a request in flight
      n_tests++;
      if ({imem_rd, p0_valid, p1_valid, p0_IR_out, p1_IR_out} !== 35'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got rd=%b v0=%b v1=%b p0=%h p1=%h want all 0",
                  imem_rd, p0_valid, p1_valid, p0_IR_out, p1_IR_out);
      end
      adv();
      drive(0, 0, 0, 0);
      n_tests++;
      if (p0_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 9'd0) begin
         n_fail++;
         $display("FAIL midreset_restart: got v0=%b rd=%b addr=%h want 0 1 000", p0_valid, imem_rd, imem_addr);
      end
      adv();
      drive(0, 0, 0, 0);
      n_tests++;
      if (p0_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_stale: got v0=%b want 0", p0_valid);
      end
      adv();
      drive(0, 0, 0, 0);
      n_tests++;
      if (p0_valid !== 1'b1 || p0_IR_out !== 16'hA000) begin
         n_fail++;
         $display("FAIL midreset_first: got v0=%b p0=%h want 1 A000", p0_valid, p0_IR_out);
      end
      adv();
   endtask

   task automatic test_random();
      int r;
      bit ev0, ev1;
      logic [15:0] e0, e1;
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, 99);
         drive(r < 2, r >= 2 && r < 10, 9'($urandom), 2'($urandom_range(0, 3)));
         ev0 = !reset && mq.size() >= 1;
         ev1 = !reset && mq.size() >= 2;
         e0  = ev0 ? mq[0] : 16'd0;
         e1  = ev1 ? mq[1] : 16'd0;
         n_tests++;
         if (imem_rd !== m_rd() || (m_rd() && imem_addr !== m_addr())) begin
            n_fail++;
            $display("FAIL rand_req c%0d: got rd=%b addr=%h want rd=%b addr=%h", c, imem_rd, imem_addr, m_rd(), m_addr());
         end
         n_tests++;
         if (p0_valid !== ev0 || p0_IR_out !== e0) begin
            n_fail++;
            $display("FAIL rand_p0 c%0d: got v=%b d=%h want v=%b d=%h", c, p0_valid, p0_IR_out, ev0, e0);
         end
         n_tests++;
         if (p1_valid !== ev1 || p1_IR_out !== e1) begin
            n_fail++;
            $display("FAIL rand_p1 c%0d: got v=%b d=%h want v=%b d=%h", c, p1_valid, p1_IR_out, ev1, e1);
         end
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_dual();
      test_single();
      test_overtake();
      test_redirect();
      test_midreset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
